// File: rtl/tsu_queue_reader_if.sv
// TSU queue reader bus: queue read port plus host register window.
// The reader itself connects through the slave modport.
interface tsu_queue_reader_if #(
  parameter int ADDR_W = 2
);
  logic [7:0]        q_rd_stat;
  logic [63:0]       q_rd_data;
  logic              q_rd_en;
  logic              host_rd;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_rdata;
  logic              ts_irq;

  modport master (
    output q_rd_stat,
    output q_rd_data,
    output host_rd,
    output host_addr,
    input  q_rd_en,
    input  host_rdata,
    input  ts_irq
  );

  modport slave (
    input  q_rd_stat,
    input  q_rd_data,
    input  host_rd,
    input  host_addr,
    output q_rd_en,
    output host_rdata,
    output ts_irq
  );
endinterface

// File: rtl/tsu_queue_reader.sv
// Pops TSU timestamp entries one at a time into a holding register
// and exposes them to the host as a 4-register 32-bit window.
module tsu_queue_reader #(
  parameter int ADDR_W = 2
) (
  input  logic              q_rd_clk,
  input  logic              q_rst_n,
  tsu_queue_reader_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_FULL  = 3'd3;
  localparam logic [2:0] S_GUARD = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [63:0]       hold;
  logic              valid;
  logic [31:0]       cnt;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        reg_sel;
  logic              consume;

  assign addr    = bus.host_addr;
  assign reg_sel = addr[1:0];
  assign consume = bus.host_rd && (reg_sel == 2'd2) && valid;

  assign bus.q_rd_en    = (state == S_POP);
  assign bus.ts_irq     = valid;
  assign bus.host_rdata = rdata;

  // Next-state: one entry in flight, guard cycle after each consume
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.q_rd_stat != 8'd0) state_nx = S_POP;
      S_POP:   state_nx = S_CAPT;
      S_CAPT:  state_nx = S_FULL;
      S_FULL:  if (consume) state_nx = S_GUARD;
      S_GUARD: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge q_rd_clk or negedge q_rst_n) begin
    if (!q_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Holding register, valid flag and consume counter
  always_ff @(posedge q_rd_clk or negedge q_rst_n) begin
    if (!q_rst_n) begin
      hold  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      if (state == S_CAPT) begin
        hold  <= bus.q_rd_data;
        valid <= 1'b1;
      end else if (consume) begin
        valid <= 1'b0;
        cnt   <= cnt + 32'd1;
      end
    end
  end

  // Registered host read data, sampled before this read's side effects
  always_ff @(posedge q_rd_clk or negedge q_rst_n) begin
    if (!q_rst_n) begin
      rdata <= '0;
    end else if (bus.host_rd) begin
      unique case (1'b1)
        (reg_sel == 2'd0): rdata <= {23'b0, valid, bus.q_rd_stat};
        (reg_sel == 2'd1): rdata <= hold[63:32];
        (reg_sel == 2'd2): rdata <= hold[31:0];
        (reg_sel == 2'd3): rdata <= cnt;
        default:           rdata <= '0;
      endcase
    end
  end

endmodule
